// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator (I/S/B/J/U, optional CSR zimm) feeding a 2-entry elastic buffer.
// Define IMM_ZICSR_EN to decode immSrc=101 as the zero-extended CSR zimm.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       immSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Handshake: an entry moves in on in_valid && in_ready and out on
  // out_valid && out_ready; in_ready is derived from registered count only.

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0] raw32;
  entry_t      dec;
  entry_t      slot0_q, slot0_d;
  entry_t      slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;
  logic        unused_opcode;

  assign unused_opcode = ^inst[6:0];

  // All formats are built as a 32-bit value whose bit 31 is the sign; zimm
  // has bit 31 clear, so a single sign-extension serves every format.
  always_comb begin
    raw32       = '0;
    dec.illegal = 1'b0;
    case (immSrc)
      3'b000: raw32 = {{20{inst[31]}}, inst[31:20]};
      3'b001: raw32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'b010: raw32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'b011: raw32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'b100: raw32 = {inst[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
      3'b101: raw32 = {27'b0, inst[19:15]};
`endif
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(raw32));
    dec.tag = in_tag;
  end

  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Slot 0 is the head. It is only overwritten by a new head entry, so the
  // outputs keep their last value once the buffer drains.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = dec;
          else                 slot1_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) slot0_d = dec;
          else begin
            slot0_d = slot1_q;
            slot1_d = dec;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign out_imm     = slot0_q.imm;
  assign out_illegal = slot0_q.illegal;
  assign out_tag     = slot0_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; a scoreboard
// queue holds hand-computed results that a negedge monitor pops on each output transfer.
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;
  localparam int EXP_W = 64 + 1 + TAG_W;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic [31:0]      inst;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready_32, in_ready_64, out_valid_32, out_valid_64;
  logic             ill_32, ill_64;
  logic [31:0]      imm_32;
  logic [63:0]      imm_64;
  logic [TAG_W-1:0] tag_32, tag_64;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  int               n_checks = 0;
  int               n_fail   = 0;

  logic [63:0]      z_imm;
  logic             z_ill;

  // clock / reset
  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
    .inst(inst), .immSrc(imm_src), .in_tag(in_tag), .out_valid(out_valid_32),
    .out_ready(out_ready), .out_imm(imm_32), .out_illegal(ill_32), .out_tag(tag_32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
    .inst(inst), .immSrc(imm_src), .in_tag(in_tag), .out_valid(out_valid_64),
    .out_ready(out_ready), .out_imm(imm_64), .out_illegal(ill_64), .out_tag(tag_64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the entry is accepted
  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [TAG_W-1:0] t,
                      input logic [63:0] ei, input logic el);
    int waited = 0;
    inst     = i;
    imm_src  = s;
    in_tag   = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_32 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_32) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tag %0d never accepted", t);
    end else begin
      check("in_ready_64", {63'b0, in_ready_64}, 64'd1);
      exp_q.push_back({el, t, ei});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && !flush && out_valid_32 && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: tag %0d imm %h with no entry expected", tag_32, imm_64);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_valid_64", {63'b0, out_valid_64}, 64'd1);
        check("imm_64", imm_64, mon_e[63:0]);
        check("imm_32", {32'b0, imm_32}, {32'b0, mon_e[31:0]});
        check("illegal_64", {63'b0, ill_64}, {63'b0, mon_e[EXP_W-1]});
        check("illegal_32", {63'b0, ill_32}, {63'b0, mon_e[EXP_W-1]});
        check("tag_64", 64'(tag_64), 64'(mon_e[63+TAG_W:64]));
        check("tag_32", 64'(tag_32), 64'(mon_e[63+TAG_W:64]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef IMM_ZICSR_EN
    z_imm = 64'h1F;
    z_ill = 1'b0;
`else
    z_imm = 64'h0;
    z_ill = 1'b1;
`endif
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = '0; imm_src = '0; in_tag = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready_32}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid_32}, 64'd0);
    check("rst_imm_64", imm_64, 64'd0);
    check("rst_illegal", {63'b0, ill_32}, 64'd0);
    check("rst_tag", 64'(tag_32), 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'b0, in_ready_32}, 64'd1);
    check("post_rst_out_valid", {63'b0, out_valid_32}, 64'd0);

    // T1: I-format all ones, one-cycle latency
    sync();
    out_ready = 1'b1;
    send(32'hFFF00093, 3'b000, 5'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_latency_valid", {63'b0, out_valid_32}, 64'd1);

    // streaming vectors, push and pop together every cycle
    sync();
    send(32'h06400093, 3'b000, 5'd2, 64'h64, 1'b0);
    send(32'h00812623, 3'b001, 5'd3, 64'hC, 1'b0);
    send(32'h008000EF, 3'b010, 5'd4, 64'h8, 1'b0);
    send(32'hFF5FF06F, 3'b010, 5'd5, 64'hFFFFFFFF_FFFFFFF4, 1'b0);
    send(32'h80000037, 3'b100, 5'd6, 64'hFFFFFFFF_80000000, 1'b0);
    // beq x0,x0,-4: inst[7]=1 so imm[11]=1
    send(32'hFE000EE3, 3'b011, 5'd7, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    send(32'h12345037, 3'b100, 5'd8, 64'h12345000, 1'b0);
    send(32'hFFF00093, 3'b110, 5'd9, 64'h0, 1'b1);
    in_valid = 1'b0;
    drain();

    // T3: backpressure, third push held off until space frees
    sync();
    out_ready = 1'b0;
    send(32'h00100093, 3'b000, 5'd1, 64'h1, 1'b0);
    send(32'hFE112E23, 3'b001, 5'd2, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    check("t3_full_in_ready", {63'b0, in_ready_32}, 64'd0);
    fork
      send(32'h00001037, 3'b100, 5'd3, 64'h1000, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_pop_cycle_in_ready", {63'b0, in_ready_32}, 64'd0);
        @(negedge clk);
        check("t3_after_pop_in_ready", {63'b0, in_ready_32}, 64'd1);
      end
    join
    in_valid = 1'b0;
    drain();

    // T4: flush when full with a pending input, then flush when empty
    sync();
    out_ready = 1'b0;
    send(32'h00200093, 3'b000, 5'd4, 64'h2, 1'b0);
    send(32'h00300093, 3'b000, 5'd5, 64'h3, 1'b0);
    inst = 32'h00400093; imm_src = 3'b000; in_tag = 5'd9;
    in_valid = 1'b1;
    flush = 1'b1;
    sync();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("t4_out_valid", {63'b0, out_valid_32}, 64'd0);
    check("t4_in_ready", {63'b0, in_ready_32}, 64'd1);
    inst = 32'h00500093; in_tag = 5'd10;
    in_valid = 1'b1;
    flush = 1'b1;
    sync();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t4_empty_after_flush", {63'b0, out_valid_32}, 64'd0);

    // T5: asynchronous reset mid-cycle with one entry held
    sync();
    out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 5'd7, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", {63'b0, out_valid_32}, 64'd0);
    check("t5_imm_64", imm_64, 64'd0);
    check("t5_imm_32", {32'b0, imm_32}, 64'd0);
    check("t5_tag", 64'(tag_64), 64'd0);
    check("t5_in_ready", {63'b0, in_ready_32}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    sync();
    check("t5_release_in_ready", {63'b0, in_ready_32}, 64'd1);
    check("t5_release_out_valid", {63'b0, out_valid_32}, 64'd0);

    // T6: zimm select and an undefined select
    out_ready = 1'b1;
    send(32'h000F8073, 3'b101, 5'd11, z_imm, z_ill);
    send(32'h000F8073, 3'b111, 5'd12, 64'h0, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
